// File: rtl/data_memory_responder.sv
// Data-memory responder for the MEM stage: one load/store in flight, answered a fixed
// LATENCY cycles after acceptance, with word/byte lanes (big-endian) and error flagging.
module data_memory_responder #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic                  size,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [15:0]           wdata,
  output logic                  busy,
  output logic                  ack,
  output logic [15:0]           rdata,
  output logic                  err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = 4'((LATENCY > 1) ? (LATENCY - 2) : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    we_q, size_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [15:0]             wdata_q;
  logic [15:0]             ram_q [DEPTH_WORDS];
  logic                    err_q;
  logic [15:0]             rdata_q;

  logic                    accept, fire;
  logic                    op_we, op_size;
  logic [ADDR_WIDTH-1:0]   op_addr;
  logic [15:0]             op_wdata;
  logic [ADDR_WIDTH-2:0]   word_idx;
  logic [IDX_W-1:0]        ram_idx;
  logic                    op_err;
  logic [15:0]             cur_word, load_val, store_val;

  function automatic logic [15:0] sext_byte(input logic signed [7:0] b);
    return {{8{b[7]}}, b};
  endfunction

  assign busy   = (state_q == S_WAIT);
  assign ack    = (state_q == S_RESP);
  assign err    = err_q;
  assign rdata  = rdata_q;
  assign accept = req && !busy;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire    = 1'b0;
    case (state_q)
      S_IDLE, S_RESP: begin
        state_d = S_IDLE;
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = S_RESP;
            fire    = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          fire    = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // An access fired from IDLE/RESP (single-cycle latency) executes straight from the inputs.
  always_comb begin
    op_we    = busy ? we_q    : we;
    op_size  = busy ? size_q  : size;
    op_addr  = busy ? addr_q  : addr;
    op_wdata = busy ? wdata_q : wdata;
    word_idx = op_addr[ADDR_WIDTH-1:1];
    ram_idx  = word_idx[IDX_W-1:0];
    op_err   = (!op_size && op_addr[0]) || (32'(word_idx) >= 32'(DEPTH_WORDS));
    cur_word = ram_q[ram_idx];
    load_val = cur_word;
    store_val = op_wdata;
    if (op_size) begin
      load_val  = op_addr[0] ? sext_byte(cur_word[7:0]) : sext_byte(cur_word[15:8]);
      store_val = op_addr[0] ? {cur_word[15:8], op_wdata[7:0]}
                             : {op_wdata[7:0], cur_word[7:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
      rdata_q <= 16'h0000;
      for (int i = 0; i < DEPTH_WORDS; i++) ram_q[i] <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= fire && op_err;
      if (fire) begin
        if (op_err)
          rdata_q <= 16'h0000;
        else if (op_we)
          ram_q[ram_idx] <= store_val;
        else
          rdata_q <= load_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= we;
      size_q  <= size;
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: three latencies share one stimulus stream and are
// checked every cycle against a scheduled-operation reference model.
module tb_data_memory_responder;

  logic        clk = 1'b0;
  logic        rst, req, we, size;
  logic [15:0] addr, wdata;
  logic [2:0]  busy_w, ack_w, err_w;
  logic [15:0] rdata_w [3];

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  data_memory_responder #(.ADDR_WIDTH(16), .DEPTH_WORDS(256), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .addr(addr), .wdata(wdata),
    .busy(busy_w[0]), .ack(ack_w[0]), .rdata(rdata_w[0]), .err(err_w[0]));
  data_memory_responder #(.ADDR_WIDTH(16), .DEPTH_WORDS(256), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .addr(addr), .wdata(wdata),
    .busy(busy_w[1]), .ack(ack_w[1]), .rdata(rdata_w[1]), .err(err_w[1]));
  data_memory_responder #(.ADDR_WIDTH(16), .DEPTH_WORDS(256), .LATENCY(5)) u_l5 (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .addr(addr), .wdata(wdata),
    .busy(busy_w[2]), .ack(ack_w[2]), .rdata(rdata_w[2]), .err(err_w[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: each instance holds at most one pending op that executes at a due cycle.
  int          lat_m [3] = '{2, 1, 5};
  logic [15:0] mem_m [3][256];
  bit          pend_m [3], ack_m [3], err_m [3];
  int          due_m [3];
  bit          pwe_m [3], psz_m [3];
  logic [15:0] paddr_m [3], pwd_m [3], rd_m [3];
  int          cyc = 0;

  task automatic model_step();
    int idx, w, d, b;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        for (int i = 0; i < 256; i++) mem_m[k][i] = 16'h0000;
        pend_m[k] = 0; ack_m[k] = 0; err_m[k] = 0; rd_m[k] = 16'h0000;
      end else begin
        ack_m[k] = 0; err_m[k] = 0;
        if (!pend_m[k] && req) begin
          pend_m[k] = 1; due_m[k] = cyc + lat_m[k];
          pwe_m[k] = we; psz_m[k] = size; paddr_m[k] = addr; pwd_m[k] = wdata;
        end
        if (pend_m[k] && due_m[k] == cyc + 1) begin
          pend_m[k] = 0;
          ack_m[k] = 1;
          idx = int'(paddr_m[k]) / 2;
          if ((!psz_m[k] && paddr_m[k][0]) || idx >= 256) begin
            err_m[k] = 1;
            rd_m[k] = 16'h0000;
          end else begin
            w = int'(mem_m[k][idx]);
            d = int'(pwd_m[k]);
            if (pwe_m[k]) begin
              if (!psz_m[k]) w = d;
              else if (paddr_m[k][0]) w = (w / 256) * 256 + d % 256;
              else w = (d % 256) * 256 + w % 256;
              mem_m[k][idx] = 16'(w);
            end else if (!psz_m[k]) begin
              rd_m[k] = 16'(w);
            end else begin
              b = paddr_m[k][0] ? w % 256 : w / 256;
              rd_m[k] = (b >= 128) ? 16'(b - 256) : 16'(b);
            end
          end
        end
      end
    end
    cyc++;
  endtask

  initial forever begin
    @(posedge clk);
    if (rst) chk_en = 1'b1;
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("busy_L%0d", lat_m[k]),  busy_w[k],  pend_m[k]);
        chk($sformatf("ack_L%0d", lat_m[k]),   ack_w[k],   ack_m[k]);
        chk($sformatf("err_L%0d", lat_m[k]),   err_w[k],   err_m[k]);
        chk($sformatf("rdata_L%0d", lat_m[k]), rdata_w[k], rd_m[k]);
      end
    end
  end

  // Drive a request and hold it until the LATENCY=2 instance accepts; returns one cycle after.
  task automatic issue(input bit w, input bit s, input logic [15:0] a, input logic [15:0] d,
                       input bit sync);
    int n;
    if (sync) @(negedge clk);
    req = 1'b1; we = w; size = s; addr = a; wdata = d;
    n = 0;
    while (busy_w[0] && n < 30) begin @(negedge clk); n++; end
    if (busy_w[0]) chk("issue_timeout", busy_w[0], 0);
    @(negedge clk);
  endtask

  task automatic wait_ack0(input string tag);
    int n;
    n = 0;
    while (!ack_w[0] && n < 30) begin @(negedge clk); n++; end
    if (!ack_w[0]) chk({tag, "_timeout"}, ack_w[0], 1);
  endtask

  task automatic op(input bit w, input bit s, input logic [15:0] a, input logic [15:0] d,
                    input string tag);
    issue(w, s, a, d, 1'b1);
    req = 1'b0;
    wait_ack0(tag);
  endtask

  initial begin
    int lat [3];
    int cnt;
    rst = 1'b1; req = 1'b0; we = 1'b0; size = 1'b0; addr = 16'h0; wdata = 16'h0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy_w[0], 0);
    chk("rst_ack", ack_w[0], 0);
    chk("rst_rdata", rdata_w[0], 16'h0000);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Latency of each instance from a common accept cycle
    req = 1'b1; we = 1'b0; size = 1'b0; addr = 16'h0010;
    lat = '{0, 0, 0};
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req = 1'b0;
        chk("t1_busy_t1", busy_w[0], 1);
      end
      if (c == 2) begin
        chk("t1_busy_t2", busy_w[0], 0);
        chk("t1_rdata", rdata_w[0], 16'h0000);
        chk("t1_err", err_w[0], 0);
      end
      for (int k = 0; k < 3; k++) if (ack_w[k] && lat[k] == 0) lat[k] = c;
    end
    chk("lat_L2", lat[0], 2);
    chk("lat_L1", lat[1], 1);
    chk("lat_L5", lat[2], 5);

    // Store, then a load accepted in the store's ack cycle
    issue(1'b1, 1'b0, 16'h0020, 16'hBEEF, 1'b1);
    issue(1'b0, 1'b0, 16'h0020, 16'h0000, 1'b1);
    req = 1'b0;
    wait_ack0("t2_load");
    chk("t2_rdata", rdata_w[0], 16'hBEEF);

    op(1'b1, 1'b1, 16'h0021, 16'h337F, "t3_bstore");
    op(1'b0, 1'b0, 16'h0020, 16'h0000, "t3_wload");
    chk("t3_word", rdata_w[0], 16'hBE7F);
    op(1'b0, 1'b1, 16'h0020, 16'h0000, "t3_bload_hi");
    chk("t3_byte_hi", rdata_w[0], 16'hFFBE);
    op(1'b0, 1'b1, 16'h0021, 16'h0000, "t3_bload_lo");
    chk("t3_byte_lo", rdata_w[0], 16'h007F);

    op(1'b0, 1'b0, 16'h0003, 16'h0000, "t4_misalign");
    chk("t4_mis_err", err_w[0], 1);
    chk("t4_mis_rdata", rdata_w[0], 16'h0000);
    op(1'b1, 1'b0, 16'h0000, 16'h1111, "t4_store0");
    op(1'b1, 1'b0, 16'h0200, 16'h5A5A, "t4_oor");
    chk("t4_oor_err", err_w[0], 1);
    op(1'b0, 1'b0, 16'h0000, 16'h0000, "t4_reload");
    chk("t4_unchanged", rdata_w[0], 16'h1111);
    chk("t4_reload_err", err_w[0], 0);

    // Request pulsed while busy is dropped; a held request is taken once busy falls
    issue(1'b0, 1'b0, 16'h0020, 16'h0000, 1'b1);
    addr = 16'h0022; size = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (ack_w[0]) cnt++;
      @(negedge clk);
      req = 1'b0;
    end
    chk("t5_single_ack", cnt, 1);
    issue(1'b0, 1'b0, 16'h0020, 16'h0000, 1'b1);
    issue(1'b0, 1'b1, 16'h0021, 16'h0000, 1'b0);
    req = 1'b0;
    wait_ack0("t5_held");
    chk("t5_held_rdata", rdata_w[0], 16'h007F);

    // Reset right after accepting a store aborts it
    issue(1'b1, 1'b0, 16'h0030, 16'h1234, 1'b1);
    req = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (ack_w[0]) cnt++;
      @(negedge clk);
    end
    chk("t6_no_ack", cnt, 0);
    op(1'b0, 1'b0, 16'h0030, 16'h0000, "t6_load30");
    chk("t6_ram30", rdata_w[0], 16'h0000);
    op(1'b0, 1'b0, 16'h0020, 16'h0000, "t6_load20");
    chk("t6_ram20", rdata_w[0], 16'h0000);

    // Randomised traffic against the model
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      rst   = ($urandom_range(0, 299) == 0);
      req   = $urandom_range(0, 1) == 1;
      we    = $urandom_range(0, 1) == 1;
      size  = $urandom_range(0, 1) == 1;
      wdata = 16'($urandom);
      case ($urandom_range(0, 7))
        5:       addr = 16'h01FC + 16'($urandom_range(0, 7));
        6:       addr = 16'($urandom);
        7:       addr = 16'($urandom_range(0, 511));
        default: addr = 16'($urandom_range(0, 63));
      endcase
    end
    @(negedge clk);
    rst = 1'b0; req = 1'b0;
    repeat (8) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, miscompares so far %0d", n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
